// File: rtl/seg_bcd_ctrl.sv
// Binary-to-BCD sequencer for the 8-digit seven-segment decoder (iterative double-dabble, one bit per cycle).
// Latency: digits, overflow and the done pulse update WIDTH+1 cycles after the accepting edge.
// Backpressure: in_ready is low while a conversion runs; requests seen while busy are dropped, not queued.
module seg_bcd_ctrl #(
    parameter int WIDTH   = 27,
    parameter int MAX_VAL = 99999999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             lz_blank,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       num0,
    output logic [3:0]       num1,
    output logic [3:0]       num2,
    output logic [3:0]       num3,
    output logic [3:0]       num4,
    output logic [3:0]       num5,
    output logic [3:0]       num6,
    output logic [3:0]       num7
);

    localparam int ITER_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    shift_q;
    logic [31:0]         bcd_q;
    logic [ITER_W-1:0]   iter_q;
    logic                lz_q;
    logic                ovf_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                overflow_q;
    logic [31:0]         num_q;

    logic [31:0]         bcd_adj_d;
    logic [31:0]         disp_d;
    logic                seen_d;

    // Double-dabble correction: each nibble >= 5 gets +3 so the following shift carries into the next decade.
    // The add stays inside the nibble (max 9+3 = 12), so nothing crosses nibble boundaries.
    always_comb begin
        bcd_adj_d = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Display digits from the final BCD value: overflow blanks everything, otherwise optional leading-zero blanking.
    // Digit 0 is never blanked so a value of zero still shows a single "0".
    always_comb begin
        disp_d = bcd_q;
        seen_d = 1'b0;
        if (ovf_q) begin
            disp_d = '1;
        end else if (lz_q) begin
            for (int i = 7; i >= 1; i--) begin
                if (bcd_q[i*4 +: 4] != 4'd0) begin
                    seen_d = 1'b1;
                end
                if (!seen_d) begin
                    disp_d[i*4 +: 4] = 4'hF;
                end
            end
        end
    end

    // Control FSM with registered handshake, status and digit outputs; digits only move on the FINISH edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            lz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            num_q      <= '1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        shift_q    <= in_data;
                        bcd_q      <= '0;
                        iter_q     <= '0;
                        lz_q       <= lz_blank;
                        ovf_q      <= (in_data > WIDTH'(MAX_VAL));
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {bcd_q, shift_q} <= {bcd_adj_d, shift_q} << 1;
                    iter_q           <= iter_q + 1'b1;
                    if (iter_q == ITER_W'(WIDTH - 1)) begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    num_q      <= disp_d;
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign num0     = num_q[3:0];
    assign num1     = num_q[7:4];
    assign num2     = num_q[11:8];
    assign num3     = num_q[15:12];
    assign num4     = num_q[19:16];
    assign num5     = num_q[23:20];
    assign num6     = num_q[27:24];
    assign num7     = num_q[31:28];

endmodule

// File: tb/tb_seg_bcd_ctrl.sv
// Directed bench for seg_bcd_ctrl: reset state, conversion, blanking, overflow, back-to-back, reset abort.
// Expected digits are written as hex so each nibble reads as the decimal digit (F = blank).
module tb_seg_bcd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_data;
    logic        lz_blank;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  num0, num1, num2, num3, num4, num5, num6, num7;
    logic [31:0] nums;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign nums = {num7, num6, num5, num4, num3, num2, num1, num0};

    seg_bcd_ctrl #(.WIDTH(27), .MAX_VAL(99999999)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .lz_blank (lz_blank),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .num0     (num0),
        .num1     (num1),
        .num2     (num2),
        .num3     (num3),
        .num4     (num4),
        .num5     (num5),
        .num6     (num6),
        .num7     (num7)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for acceptance, then count cycles from the accepting edge to done.
    task automatic send_wait(input logic [26:0] v, input logic lz, output int lat, output logic leak);
        logic [31:0] snap;
        int k;
        in_data  = v;
        lz_blank = lz;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 40) begin
            tick();
            k++;
        end
        snap = nums;
        tick();
        in_valid = 1'b0;
        lat  = 0;
        leak = 1'b0;
        while (!done && lat < 40) begin
            if (nums !== snap) leak = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (5) tick();
        n_cmp++; if (nums !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL reset_nums: got %h expected ffffffff", nums); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_convert();
        int lat;
        logic leak;
        send_wait(27'd12345678, 1'b0, lat, leak);
        n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL conv_latency: got %0d expected 28", lat); end
        n_cmp++; if (leak !== 1'b0) begin n_bad++; $display("FAIL conv_no_leak: got %b expected 0", leak); end
        n_cmp++; if (nums !== 32'h12345678) begin n_bad++; $display("FAIL conv_nums: got %h expected 12345678", nums); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL conv_overflow: got %b expected 0", overflow); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL conv_done_one_cycle: got %b expected 0", done); end
        n_cmp++; if (nums !== 32'h12345678) begin n_bad++; $display("FAIL conv_nums_hold: got %h expected 12345678", nums); end
    endtask

    task automatic test_blanking();
        int lat;
        logic leak;
        send_wait(27'd42, 1'b1, lat, leak);
        n_cmp++; if (nums !== 32'hFFFFFF42) begin n_bad++; $display("FAIL blank_42: got %h expected ffffff42", nums); end
        send_wait(27'd0, 1'b1, lat, leak);
        n_cmp++; if (nums !== 32'hFFFFFFF0) begin n_bad++; $display("FAIL blank_zero: got %h expected fffffff0", nums); end
        send_wait(27'd0, 1'b0, lat, leak);
        n_cmp++; if (nums !== 32'h00000000) begin n_bad++; $display("FAIL noblank_zero: got %h expected 00000000", nums); end
        send_wait(27'd1000, 1'b1, lat, leak);
        n_cmp++; if (nums !== 32'hFFFF1000) begin n_bad++; $display("FAIL blank_1000: got %h expected ffff1000", nums); end
    endtask

    task automatic test_overflow();
        int lat;
        logic leak;
        send_wait(27'd99999999, 1'b0, lat, leak);
        n_cmp++; if (nums !== 32'h99999999) begin n_bad++; $display("FAIL max_nums: got %h expected 99999999", nums); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL max_overflow: got %b expected 0", overflow); end
        send_wait(27'd100000000, 1'b1, lat, leak);
        n_cmp++; if (nums !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL ovf_nums: got %h expected ffffffff", nums); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL ovf_latency: got %0d expected 28", lat); end
        send_wait(27'd7, 1'b0, lat, leak);
        n_cmp++; if (nums !== 32'h00000007) begin n_bad++; $display("FAIL after_ovf_nums: got %h expected 00000007", nums); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL after_ovf_flag: got %b expected 0", overflow); end
    endtask

    task automatic test_back_to_back();
        int k;
        int lat;
        in_data  = 27'd11111111;
        lz_blank = 1'b0;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 40) begin
            tick();
            k++;
        end
        tick();
        in_data = 27'd22222222;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected 28", lat); end
        n_cmp++; if (nums !== 32'h11111111) begin n_bad++; $display("FAIL b2b_first_nums: got %h expected 11111111", nums); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_on_done: got %b expected 1", in_ready); end
        tick();
        n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept_on_done: got busy=%b in_ready=%b expected busy=1 in_ready=0", busy, in_ready);
        end
        in_valid = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 5) begin
                in_data  = 27'd33333333;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected 28", lat); end
        n_cmp++; if (nums !== 32'h22222222) begin n_bad++; $display("FAIL b2b_second_nums: got %h expected 22222222", nums); end
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_pulse_ignored: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int k;
        logic seen_done;
        in_data  = 27'd55;
        lz_blank = 1'b0;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 40) begin
            tick();
            k++;
        end
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if (nums !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL abort_nums: got %h expected ffffffff", nums); end
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b expected 0", seen_done); end
        n_cmp++; if (nums !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL abort_nums_hold: got %h expected ffffffff", nums); end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        lz_blank = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        test_reset();
        test_convert();
        test_blanking();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_bcd_ctrl.md
Name: seg_bcd_ctrl

Overview:
Sequencer that converts a binary value into eight BCD digit nibbles for the 8-digit seven-segment decoder on the NVBoard display path. It accepts a value over a valid/ready handshake and runs an iterative double-dabble conversion, one bit per cycle. It then applies optional leading-zero blanking and overflow handling, and drives num0..num7 of the decoder from registered outputs. Codes 4'hA-4'hF decode to all segments off, so 4'hF is the blank code.

Parameters:
WIDTH, 27, binary input width; the conversion runs exactly WIDTH iterations (27 bits cover 99,999,999).
MAX_VAL, 99999999, largest displayable value; anything larger is overflow.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  request: in_data/lz_blank valid
in_ready  output  1  controller idle, request accepted on in_valid&in_ready
in_data  input  WIDTH  unsigned binary value to display
lz_blank  input  1  enable leading-zero blanking, sampled with in_data
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: new digits on num0..num7
overflow  output  1  last accepted value exceeded MAX_VAL
num0..num7  output  4 each  BCD digit to decoder; num0 = least significant; 4'hF = blank

Behaviour:
- Reset (synchronous, active-high, wins over all other events): state=IDLE, num0..num7=4'hF, overflow=0, done=0, busy=0, in_ready=1.
- Reset mid-conversion aborts the conversion. No done pulse is produced and the outputs go blank.
- FSM states: IDLE, SHIFT, FINISH.
  - IDLE: in_ready=1, busy=0. On in_valid&in_ready at edge E0:
    - load shift reg = in_data and BCD reg (32 bits) = 0
    - iter=0
    - latch lz_blank and ovf = (in_data > MAX_VAL)
    - go to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each cycle, every BCD nibble >= 5 gets +3, then {bcd,shift} shifts left by 1. iter increments each cycle. After the WIDTH-th iteration (edge E27 for WIDTH=27), go to FINISH.
  - FINISH: busy=1. At edge E28:
    - register num0..num7 from the BCD reg after blanking/overflow rules
    - overflow <= ovf
    - done <= 1 for exactly one cycle
    - state <= IDLE.
- Latency: num outputs change at edge E0+WIDTH+1 (28 cycles after acceptance). in_ready is high again in the same cycle done is high, so back-to-back requests are accepted on the done cycle.
- Throughput: one conversion per WIDTH+2 cycles max.
- Overflow: num0..num7 all 4'hF and overflow=1. The overflow flag holds until the next FINISH. A non-overflow result clears it.
- Leading-zero blanking (lz_blank latched = 1): every digit above the most significant nonzero digit becomes 4'hF. num0 is never blanked, so value 0 shows a single "0". With lz_blank=0, all eight digits show, including zeros.
- num outputs hold their value from the last FINISH and are stable during SHIFT (no intermediate values leak).
- in_valid while busy: ignored, not queued. in_data/lz_blank changes after acceptance have no effect.
- in_valid may drop without acceptance; there is no requirement to hold.
- Width rules: the BCD reg is 32 bits (8 nibbles); +3 per nibble is 4-bit and never carries across nibbles; the iteration counter is ceil(log2(WIDTH+1)) bits.

Test Plan:
- Reset, then idle 5 cycles -> num0..num7=4'hF, in_ready=1, busy=0, done=0, overflow=0.
- Send 12345678, lz_blank=0 -> done pulse exactly 28 cycles after accept; num7..num0 = 1,2,3,4,5,6,7,8; overflow=0.
- Send 42, lz_blank=1 -> num0=2, num1=4, num2..num7=4'hF. Send 0, lz_blank=1 -> num0=0, others 4'hF. Send 0, lz_blank=0 -> all digits 0.
- Send 99999999 -> all digits 9, overflow=0. Then send 100000000 -> all digits 4'hF, overflow=1. Then send 7 -> num0=7, overflow=0.
- Hold in_valid high with 11111111 then 22222222 -> second value is accepted on the first done cycle; a pulse of in_valid while busy is ignored; the second done comes 28 cycles later.
- Assert rst at cycle 10 of a conversion of 55 -> no done pulse; outputs 4'hF; in_ready=1 the cycle after reset deasserts.
